// File: rtl/trap_peak_sampler.sv
// trap_peak_sampler: captures trapezoid flat-top height per pulse and emits it on a one-entry AXI-Stream slot; TRAP_PILEUP_REJECT_EN enables pile-up rejection
module trap_peak_sampler #(
  parameter int IN_WIDTH  = 32,
  parameter int CNT_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]  threshold,
  input  logic [CNT_WIDTH-1:0] peak_delay,
  input  logic [CNT_WIDTH-1:0] holdoff,
  output logic [IN_WIDTH-1:0]  m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          event_count,
  output logic [15:0]          drop_count,
  output logic [15:0]          pileup_count
);
  typedef enum logic [1:0] {IDLE, DELAY, WAIT_FALL, HOLDOFF} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH:0] cnt_inc;
  logic [IN_WIDTH-1:0] height, height_n;
  logic pile, pile_n, pile_hit, emit, pile_rej, above, load;
  assign above   = $signed(s_axis_tdata) > $signed(threshold);
  assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
  assign load    = emit && (!m_axis_tvalid || m_axis_tready);
`ifdef TRAP_PILEUP_REJECT_EN
  logic signed [IN_WIDTH:0] limit;
  assign limit    = $signed({height[IN_WIDTH-1], height}) + $signed({threshold[IN_WIDTH-1], threshold});
  assign pile_hit = $signed({s_axis_tdata[IN_WIDTH-1], s_axis_tdata}) > limit;
`else
  assign pile_hit = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    height_n = height;
    pile_n   = pile;
    emit     = 1'b0;
    pile_rej = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        IDLE: if (above) begin
          pile_n = 1'b0;
          if (peak_delay == '0) begin
            height_n = s_axis_tdata;
            state_n  = WAIT_FALL;
          end else begin
            cnt_n   = CNT_WIDTH'(1);
            state_n = DELAY;
          end
        end
        DELAY: if (!above) begin
          cnt_n   = '0;
          state_n = HOLDOFF;
        end else if (cnt >= peak_delay) begin
          height_n = s_axis_tdata;
          state_n  = WAIT_FALL;
        end else begin
          cnt_n = cnt_inc[CNT_WIDTH-1:0];
        end
        WAIT_FALL: if (!above) begin
          emit     = !pile;
          pile_rej = pile;
          pile_n   = 1'b0;
          cnt_n    = '0;
          state_n  = (holdoff == '0) ? IDLE : HOLDOFF;
        end else if (pile_hit) begin
          pile_n = 1'b1;
        end
        HOLDOFF: begin
          cnt_n   = cnt_inc[CNT_WIDTH-1:0];
          state_n = (cnt_inc >= {1'b0, holdoff}) ? IDLE : HOLDOFF;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= IDLE;
      cnt           <= '0;
      height        <= '0;
      pile          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      event_count   <= '0;
      drop_count    <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      height <= height_n;
      pile   <= pile_n;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= height;
        event_count   <= event_count + 32'd1;
      end else begin
        if (m_axis_tready) m_axis_tvalid <= 1'b0;
        if (emit && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end
`ifdef TRAP_PILEUP_REJECT_EN
  always_ff @(posedge clk) begin
    if (!aresetn) pileup_count <= '0;
    else if (pile_rej && pileup_count != 16'hFFFF) pileup_count <= pileup_count + 16'd1;
  end
`else
  assign pileup_count = 16'd0;
  logic unused_rej;
  assign unused_rej = pile_rej;
`endif
endmodule

// File: tb/tb_trap_peak_sampler.sv
// tb_trap_peak_sampler: directed checks of pulse capture, backpressure, aborts, gaps, pile-up and reset
module tb_trap_peak_sampler;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic [31:0] threshold = 32'd100;
  logic [13:0] peak_delay = 14'd4;
  logic [13:0] holdoff = 14'd3;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [31:0] event_count;
  logic [15:0] drop_count, pileup_count;
  int checks = 0;
  int passed = 0;
  int xfers = 0;
  logic [31:0] last_data = '0;

  trap_peak_sampler dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .threshold(threshold), .peak_delay(peak_delay), .holdoff(holdoff),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .event_count(event_count), .drop_count(drop_count), .pileup_count(pileup_count)
  );

  always #5 clk = ~clk;

  // inputs only change just after posedge, so a negedge view predicts the next edge's handshake
  always @(negedge clk) if (m_axis_tvalid && m_axis_tready) begin
    xfers++;
    last_data = m_axis_tdata;
  end

  task automatic send(input int d, input bit v);
    s_axis_tdata = d;
    s_axis_tvalid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    send(0, 0);
    send(0, 0);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    send(0, 0);
    send(0, 0);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd0) $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); else passed++;
    checks++; if (event_count !== 32'd0) $display("FAIL reset_events: got %0d want 0", event_count); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL reset_drops: got %0d want 0", drop_count); else passed++;
    checks++; if (pileup_count !== 16'd0) $display("FAIL reset_pileups: got %0d want 0", pileup_count); else passed++;
    aresetn = 1'b1;
  endtask

  task automatic test_single_pulse();
    int x0;
    do_reset();
    threshold = 100; peak_delay = 4; holdoff = 3; m_axis_tready = 1;
    x0 = xfers;
    send(0, 1); send(0, 1); send(200, 1); send(500, 1); send(800, 1);
    send(1000, 1); send(1000, 1); send(1000, 1);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL single_early: got tvalid %0b want 0", m_axis_tvalid); else passed++;
    send(50, 1);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL single_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd1000) $display("FAIL single_tdata: got %0d want 1000", m_axis_tdata); else passed++;
    checks++; if (event_count !== 32'd1) $display("FAIL single_events: got %0d want 1", event_count); else passed++;
    send(0, 1);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL single_drop_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
    send(0, 1); send(0, 1); send(0, 1);
    checks++; if (xfers - x0 !== 1) $display("FAIL single_xfers: got %0d want 1", xfers - x0); else passed++;
    checks++; if (last_data !== 32'd1000) $display("FAIL single_xfer_data: got %0d want 1000", last_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int x0;
    do_reset();
    threshold = 100; peak_delay = 4; holdoff = 0; m_axis_tready = 0;
    x0 = xfers;
    send(200, 1); send(500, 1); send(800, 1); send(1000, 1); send(1000, 1); send(50, 1);
    send(200, 1); send(500, 1); send(800, 1); send(700, 1); send(700, 1); send(50, 1);
    send(0, 1); send(0, 1);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL b2b_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd1000) $display("FAIL b2b_held_data: got %0d want 1000", m_axis_tdata); else passed++;
    checks++; if (event_count !== 32'd1) $display("FAIL b2b_events: got %0d want 1", event_count); else passed++;
    checks++; if (drop_count !== 16'd1) $display("FAIL b2b_drops: got %0d want 1", drop_count); else passed++;
    m_axis_tready = 1;
    send(0, 1);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL b2b_drain: got tvalid %0b want 0", m_axis_tvalid); else passed++;
    send(0, 1); send(0, 1);
    checks++; if (xfers - x0 !== 1) $display("FAIL b2b_xfers: got %0d want 1", xfers - x0); else passed++;
    checks++; if (last_data !== 32'd1000) $display("FAIL b2b_xfer_data: got %0d want 1000", last_data); else passed++;
  endtask

  task automatic test_short_pulse();
    int x0;
    do_reset();
    threshold = 100; peak_delay = 10; holdoff = 3; m_axis_tready = 1;
    x0 = xfers;
    for (int i = 0; i < 5; i++) send(200, 1);
    send(50, 1);
    send(0, 1);
    checks++; if (xfers - x0 !== 0) $display("FAIL short_no_output: got %0d transfers want 0", xfers - x0); else passed++;
    checks++; if (event_count !== 32'd0) $display("FAIL short_events: got %0d want 0", event_count); else passed++;
    peak_delay = 0;
    send(0, 1);
    send(300, 1);
    send(0, 1);
    send(400, 1);
    send(0, 1);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL short_idle_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd400) $display("FAIL short_idle_data: got %0d want 400", m_axis_tdata); else passed++;
    checks++; if (event_count !== 32'd1) $display("FAIL short_idle_events: got %0d want 1", event_count); else passed++;
    send(0, 1); send(0, 1); send(0, 1);
  endtask

  task automatic test_tvalid_gaps();
    do_reset();
    threshold = 100; peak_delay = 4; holdoff = 3; m_axis_tready = 1;
    send(0, 1); send(5000, 0); send(0, 1); send(5000, 0);
    send(200, 1); send(5000, 0); send(500, 1); send(5000, 0);
    send(800, 1); send(5000, 0); send(1000, 1); send(5000, 0);
    send(1000, 1); send(5000, 0); send(1000, 1); send(5000, 0);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL gaps_early: got tvalid %0b want 0", m_axis_tvalid); else passed++;
    send(50, 1);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL gaps_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd1000) $display("FAIL gaps_tdata: got %0d want 1000", m_axis_tdata); else passed++;
    send(5000, 0);
    checks++; if (event_count !== 32'd1) $display("FAIL gaps_events: got %0d want 1", event_count); else passed++;
    for (int i = 0; i < 4; i++) send(0, 1);
  endtask

  task automatic test_pileup();
    do_reset();
    threshold = 100; peak_delay = 4; holdoff = 3; m_axis_tready = 1;
    send(0, 1); send(200, 1); send(500, 1); send(800, 1); send(1000, 1); send(1000, 1);
    send(1200, 1); send(50, 1);
`ifdef TRAP_PILEUP_REJECT_EN
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL pileup_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
    checks++; if (pileup_count !== 16'd1) $display("FAIL pileup_count: got %0d want 1", pileup_count); else passed++;
    checks++; if (event_count !== 32'd0) $display("FAIL pileup_events: got %0d want 0", event_count); else passed++;
`else
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL pileup_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 32'd1000) $display("FAIL pileup_tdata: got %0d want 1000", m_axis_tdata); else passed++;
    checks++; if (pileup_count !== 16'd0) $display("FAIL pileup_count: got %0d want 0", pileup_count); else passed++;
`endif
    for (int i = 0; i < 4; i++) send(0, 1);
  endtask

  task automatic test_reset_midpulse();
    do_reset();
    threshold = 100; peak_delay = 4; holdoff = 3; m_axis_tready = 0;
    send(200, 1); send(500, 1); send(800, 1); send(1000, 1); send(1000, 1); send(50, 1);
    send(0, 1); send(0, 1); send(0, 1);
    send(200, 1); send(500, 1); send(800, 1); send(700, 1); send(700, 1); send(700, 1);
    checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL midrst_pre_tvalid: got %0b want 1", m_axis_tvalid); else passed++;
    checks++; if (event_count !== 32'd1) $display("FAIL midrst_pre_events: got %0d want 1", event_count); else passed++;
    aresetn = 1'b0;
    send(700, 1);
    aresetn = 1'b1;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
    checks++; if (event_count !== 32'd0) $display("FAIL midrst_events: got %0d want 0", event_count); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL midrst_drops: got %0d want 0", drop_count); else passed++;
    send(50, 1); send(0, 1);
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_post_tvalid: got %0b want 0", m_axis_tvalid); else passed++;
    checks++; if (event_count !== 32'd0) $display("FAIL midrst_post_events: got %0d want 0", event_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_short_pulse();
    test_tvalid_gaps();
    test_pileup();
    test_reset_midpulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
